mult_arb_seq: RTL and testbench
===============================

MULT_ARB_SEQ -- requirements
Module: mult_arb_seq

Interface
REQ-001 The block SHALL have parameter bw, default 16, giving the operand width in bits; the product is 2*bw bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester 0/1 holds a multiply request.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester 0/1 request is accepted this cycle.
REQ-006 The block SHALL have ports req0_A, req0_B, req1_A and req1_B, input, bw bits each: unsigned operands.
REQ-007 The block SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-008 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-009 The block SHALL have port rsp_out, output, 2*bw bits: the unsigned product A*B.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: the requester that owns rsp_out.
REQ-011 The block SHALL have port busy, output, 1 bit: high in states CALC and DONE.

Function
REQ-012 The FSM SHALL have three states, IDLE, CALC and DONE: IDLE goes to CALC on accept; CALC goes to DONE after bw CALC cycles; DONE goes to IDLE on rsp_ready.
REQ-013 reqN_ready SHALL be the combinational result (state==IDLE) && !RESET && grant==N; at most one ready is high in any cycle.
REQ-014 Grant SHALL follow these rules: with one valid, that requester is granted; with both valid, per REQ-027/028; with none valid, nothing is accepted.
REQ-015 Accept SHALL be reqN_valid && reqN_ready, and on that edge the block SHALL: latch multiplicand={bw'0,A}, multiplier=B, acc=0, cnt=0, rsp_id=N; update last_grant=N.
REQ-016 Each CALC edge SHALL do: if multiplier[0], acc+=multiplicand (2*bw-bit add, no carry-out needed); multiplicand<<=1; multiplier>>=1; cnt++. On cnt==bw-1 the next state is DONE.
REQ-017 rsp_valid SHALL be high exactly in DONE, with rsp_out=acc; rsp_valid, rsp_out and rsp_id SHALL stay stable while rsp_ready is low (unbounded stall).
REQ-018 Latency SHALL be such that if the accept edge is edge 0, rsp_valid is high after edge bw; the minimum issue interval is bw+2 cycles (one DONE cycle, one IDLE cycle).
REQ-019 Requests arriving during CALC or DONE SHALL wait (ready low) and SHALL NOT be dropped; requesters hold valid and operands until ready.
REQ-020 Zero operands SHALL take the full bw cycles; there is no early termination.
REQ-021 The rsp_ready level in IDLE or CALC SHALL be ignored.

Reset
REQ-022 While RESET is high at an edge, the block SHALL set state=IDLE, rsp_valid=0, rsp_out=0, rsp_id=0, busy=0, cnt=0 and last_grant=1.
REQ-023 While RESET is high, req0_ready and req1_ready SHALL be forced 0.
REQ-024 RESET in CALC or DONE SHALL abort the operation with no response emitted.
REQ-025 A held request SHALL be accepted on the first IDLE edge after RESET falls.
REQ-026 RESET SHALL have priority over accept and rsp_ready in the same cycle.

Configuration
REQ-027 With MULT_ARB_RR_EN defined, on both valid the block SHALL grant the requester != last_grant (round-robin).
REQ-028 Without MULT_ARB_RR_EN, on both valid the block SHALL always grant requester 0 (fixed priority); last_grant is then unused and may be optimised away.

Structure
REQ-029 Package mult_arb_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the ID width constant (1).
REQ-030 Sub-module mult_shift_add_dp SHALL hold the acc, multiplicand, multiplier and cnt registers and the adder, with load/step controls from the FSM, and SHALL drive a last-step flag to the FSM.

Verification (bw=16)
REQ-031 Directed test: req0 with A=3, B=5 and rsp_ready=1 -> rsp_valid after edge 16, rsp_out=15, rsp_id=0.
REQ-032 Directed test: req1 with A=0xFFFF, B=0xFFFF -> rsp_out=0xFFFE0001, rsp_id=1; A=0, B=0x1234 -> rsp_out=0 after the full 16 cycles.
REQ-033 Directed test: both valid from reset, 4 operations each, with MULT_ARB_RR_EN -> rsp_id sequence 0,1,0,1,...; without MULT_ARB_RR_EN -> 0,0,0,0 then 1,1,1,1.
REQ-034 Directed test: rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_out and rsp_id unchanged, both ready low, busy=1; then rsp_ready=1 -> IDLE next edge.
REQ-035 Directed test: RESET pulse at CALC cycle 7 -> no rsp_valid; all outputs 0; a held req0 (A=7, B=9) is accepted after reset and gives 63.
REQ-036 Directed test: random 1000 requests with random valid and rsp_ready -> every rsp_out equals A*B in order, with no lost or duplicated request.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the arbitrated shift-and-add multiplier.
package mult_arb_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the requester identifier carried with each response
   localparam int ID_W = 1;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-and-add multiplier datapath: holds the accumulator, the shifting
// multiplicand/multiplier and the step counter. One partial product per step.
module mult_shift_add_dp #(
   parameter int bw = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [bw-1:0]   i_a,
   input  logic [bw-1:0]   i_b,
   output logic [2*bw-1:0] o_acc,
   output logic            o_last
);

   localparam int CW = $clog2(bw + 1);

   logic [2*bw-1:0] r_acc;
   logic [2*bw-1:0] r_mcand;
   logic [bw-1:0]   r_mplier;
   logic [CW-1:0]   r_cnt;

   // Load operands on accept, otherwise add/shift once per CALC cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc    <= {(2*bw){1'b0}};
         r_mcand  <= {(2*bw){1'b0}};
         r_mplier <= {bw{1'b0}};
         r_cnt    <= {CW{1'b0}};
      end else if (i_load) begin
         r_acc    <= {(2*bw){1'b0}};
         r_mcand  <= {{bw{1'b0}}, i_a};
         r_mplier <= i_b;
         r_cnt    <= {CW{1'b0}};
      end else if (i_step) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end else begin
            r_acc <= r_acc;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   assign o_acc  = r_acc;
   // The step being taken now is the final one (no early exit on zero operands)
   assign o_last = (r_cnt == CW'(bw - 1));

endmodule

// File: rtl/mult_arb_seq.sv
// Two-requester sequential multiplier. A single shared shift-and-add datapath
// serves one request at a time; the result is held until the consumer takes it.
// Optional feature macro: MULT_ARB_RR_EN -- round-robin grant when both
// requesters are valid (default build: requester 0 has fixed priority).
module mult_arb_seq
   import mult_arb_pkg::*;
#(
   parameter int bw = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            req0_valid,
   input  logic            req1_valid,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic [bw-1:0]   req0_A,
   input  logic [bw-1:0]   req0_B,
   input  logic [bw-1:0]   req1_A,
   input  logic [bw-1:0]   req1_B,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [2*bw-1:0] rsp_out,
   output logic [ID_W-1:0] rsp_id,
   output logic            busy
);

   state_t          r_state;
   logic            r_rsp_valid;
   logic            r_busy;
   logic [ID_W-1:0] r_rsp_id;
`ifdef MULT_ARB_RR_EN
   logic [ID_W-1:0] r_last_grant;
`endif

   logic [ID_W-1:0] w_grant;
   logic            w_accept;
   logic            w_idle;
   logic            w_last;
   logic [bw-1:0]   w_a;
   logic [bw-1:0]   w_b;

   // Pick which requester may be accepted this cycle
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef MULT_ARB_RR_EN
         w_grant = ~r_last_grant;
`else
         w_grant = 1'b0;
`endif
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end else begin
         w_grant = 1'b0;
      end
   end

   assign w_idle     = (r_state == IDLE);
   assign req0_ready = w_idle && !RESET && (w_grant == 1'b0);
   assign req1_ready = w_idle && !RESET && (w_grant == 1'b1);
   assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign w_a        = (w_grant == 1'b1) ? req1_A : req0_A;
   assign w_b        = (w_grant == 1'b1) ? req1_B : req0_B;

   mult_shift_add_dp #(.bw(bw)) u_dp (
      .i_clk   (CLK),
      .i_reset (RESET),
      .i_load  (w_accept),
      .i_step  (r_state == CALC),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_acc   (rsp_out),
      .o_last  (w_last)
   );

   // Control FSM with registered handshake/status outputs; reset aborts any op
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= IDLE;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_id    <= 1'b0;
`ifdef MULT_ARB_RR_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state  <= CALC;
                  r_busy   <= 1'b1;
                  r_rsp_id <= w_grant;
`ifdef MULT_ARB_RR_EN
                  r_last_grant <= w_grant;
`endif
               end
            end
            CALC: begin
               if (w_last) begin
                  r_state     <= DONE;
                  r_rsp_valid <= 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mult_arb_seq.sv
// Directed and randomized checks for mult_arb_seq with bw=16.
module tb_mult_arb_seq;

   localparam int BW = 16;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            req0_valid, req1_valid, req0_ready, req1_ready;
   logic [BW-1:0]   req0_A, req0_B, req1_A, req1_B;
   logic            rsp_valid, rsp_ready, busy;
   logic [2*BW-1:0] rsp_out;
   logic            rsp_id;

   int n_checks = 0;
   int n_fail   = 0;

   logic            sv_id [3] = '{1'b0, 1'b1, 1'b1};
   logic [BW-1:0]   sv_a  [3] = '{16'd3, 16'hFFFF, 16'd0};
   logic [BW-1:0]   sv_b  [3] = '{16'd5, 16'hFFFF, 16'h1234};
   logic [2*BW-1:0] sv_p  [3] = '{32'd15, 32'hFFFE0001, 32'd0};
`ifdef MULT_ARB_RR_EN
   logic exp_ids [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
   logic exp_ids [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

   mult_arb_seq #(.bw(BW)) dut (
      .CLK(CLK), .RESET(RESET),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_id(rsp_id), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RESET = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_A = 16'd1; req0_B = 16'd1; req1_A = 16'd1; req1_B = 16'd1;
      tick; tick;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_out !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", rsp_out); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id: got %b want 0", rsp_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      req0_valid = 1'b0; req1_valid = 1'b0; RESET = 1'b0;
      tick;
   endtask

   task automatic test_single_ops;
      int n;
      for (int i = 0; i < 3; i++) begin
         rsp_ready = 1'b1;
         if (sv_id[i]) begin req1_valid = 1'b1; req1_A = sv_a[i]; req1_B = sv_b[i]; end
         else begin req0_valid = 1'b1; req0_A = sv_a[i]; req0_B = sv_b[i]; end
         #1;
         n_checks++; if ((sv_id[i] ? req1_ready : req0_ready) !== 1'b1) begin n_fail++; $display("FAIL single_ready[%0d]: got 0 want 1", i); end
         tick;
         req0_valid = 1'b0; req1_valid = 1'b0;
         n_checks++; if ({busy, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL single_calc[%0d]: busy,valid got %b want 10", i, {busy, rsp_valid}); end
         n = 0;
         while (!rsp_valid && n < 40) begin tick; n++; end
         n_checks++; if (n !== 16) begin n_fail++; $display("FAIL single_latency[%0d]: got %0d want 16", i, n); end
         n_checks++; if (rsp_out !== sv_p[i]) begin n_fail++; $display("FAIL single_out[%0d]: got %0h want %0h", i, rsp_out, sv_p[i]); end
         n_checks++; if (rsp_id !== sv_id[i]) begin n_fail++; $display("FAIL single_id[%0d]: got %b want %b", i, rsp_id, sv_id[i]); end
         tick;
         n_checks++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL single_release[%0d]: busy,valid got %b want 00", i, {busy, rsp_valid}); end
      end
   endtask

   task automatic test_back_to_back;
      int k0, k1, r0, r1, nresp, en, kk;
      logic a0, a1;
      logic [2*BW-1:0] pe;
      k0 = 0; k1 = 0; r0 = 0; r1 = 0; nresp = 0;
      RESET = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL arb_reset_ready: got %b want 00", {req0_ready, req1_ready}); end
      RESET = 1'b0;
      for (int cyc = 0; cyc < 600 && nresp < 8; cyc++) begin
         req0_valid = (k0 < 4); req0_A = 16'(k0 + 1);  req0_B = 16'(k0 + 3);
         req1_valid = (k1 < 4); req1_A = 16'(k1 + 11); req1_B = 16'(k1 + 3);
         #1;
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         n_checks++; if (req0_ready && req1_ready) begin n_fail++; $display("FAIL arb_one_ready: got 11 want at most one"); end
         if (rsp_valid) begin
            en = int'(exp_ids[nresp]);
            kk = (en == 1) ? r1 : r0;
            pe = 32'((10 * en + kk + 1) * (kk + 3));
            n_checks++; if (rsp_id !== exp_ids[nresp]) begin n_fail++; $display("FAIL arb_id[%0d]: got %b want %b", nresp, rsp_id, exp_ids[nresp]); end
            n_checks++; if (rsp_out !== pe) begin n_fail++; $display("FAIL arb_out[%0d]: got %0h want %0h", nresp, rsp_out, pe); end
            if (en == 1) r1++; else r0++;
            nresp++;
         end
         tick;
         if (a0) k0++;
         if (a1) k1++;
      end
      n_checks++; if (nresp !== 8) begin n_fail++; $display("FAIL arb_count: got %0d want 8", nresp); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick;
   endtask

   task automatic test_stall;
      int n;
      rsp_ready = 1'b0; req0_valid = 1'b1; req0_A = 16'd6; req0_B = 16'd7;
      tick;
      req0_A = 16'd2; req0_B = 16'd2;
      n = 0;
      while (!rsp_valid && n < 40) begin tick; n++; end
      for (int i = 0; i < 10; i++) begin
         n_checks++; if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100) begin n_fail++; $display("FAIL stall_ctrl[%0d]: valid,busy,rdy0,rdy1 got %b want 1100", i, {rsp_valid, busy, req0_ready, req1_ready}); end
         n_checks++; if ({rsp_out, rsp_id} !== {32'd42, 1'b0}) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h/%b want 2a/0", i, rsp_out, rsp_id); end
         tick;
      end
      rsp_ready = 1'b1;
      tick;
      n_checks++; if ({rsp_valid, busy, req0_ready} !== 3'b001) begin n_fail++; $display("FAIL stall_release: valid,busy,rdy0 got %b want 001", {rsp_valid, busy, req0_ready}); end
      tick;
      req0_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin tick; n++; end
      n_checks++; if (rsp_out !== 32'd4) begin n_fail++; $display("FAIL stall_next_out: got %0h want 4", rsp_out); end
      tick;
   endtask

   task automatic test_reset_abort;
      int n;
      rsp_ready = 1'b1; req0_valid = 1'b1; req0_A = 16'd5; req0_B = 16'd5;
      tick;
      req0_A = 16'd7; req0_B = 16'd9;
      for (int i = 0; i < 7; i++) begin
         tick;
         n_checks++; if ({rsp_valid, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL abort_calc[%0d]: valid,rdy0 got %b want 00", i, {rsp_valid, req0_ready}); end
      end
      RESET = 1'b1;
      tick;
      n_checks++; if ({rsp_valid, busy, rsp_id, req0_ready, req1_ready} !== 5'b00000) begin n_fail++; $display("FAIL abort_ctrl: got %b want 00000", {rsp_valid, busy, rsp_id, req0_ready, req1_ready}); end
      n_checks++; if (rsp_out !== 32'd0) begin n_fail++; $display("FAIL abort_out: got %0h want 0", rsp_out); end
      RESET = 1'b0;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL abort_reaccept: got %b want 1", req0_ready); end
      tick;
      req0_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin tick; n++; end
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL abort_latency: got %0d want 16", n); end
      n_checks++; if ({rsp_out, rsp_id} !== {32'd63, 1'b0}) begin n_fail++; $display("FAIL abort_result: got %0h/%b want 3f/0", rsp_out, rsp_id); end
      tick;
   endtask

   task automatic test_random;
      logic [32:0] q[$];
      logic [32:0] e;
      logic c0, c1;
      int n_launch, n_rcv;
      n_launch = 0; n_rcv = 0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int cyc = 0; cyc < 60000 && n_rcv < 1000; cyc++) begin
         if (!req0_valid && n_launch < 1000 && $urandom_range(3) == 0) begin
            req0_valid = 1'b1; req0_A = 16'($urandom); req0_B = 16'($urandom); n_launch++;
         end
         if (!req1_valid && n_launch < 1000 && $urandom_range(3) == 0) begin
            req1_valid = 1'b1; req1_A = 16'($urandom); req1_B = 16'($urandom); n_launch++;
         end
         rsp_ready = 1'($urandom_range(1));
         #1;
         c0 = req0_valid && req0_ready;
         c1 = req1_valid && req1_ready;
         if (c0) q.push_back({1'b0, {16'd0, req0_A} * {16'd0, req0_B}});
         if (c1) q.push_back({1'b1, {16'd0, req1_A} * {16'd0, req1_B}});
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: got response %0h want none", rsp_out);
            end else begin
               e = q.pop_front();
               if ({rsp_id, rsp_out} !== e) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %b/%0h want %b/%0h", n_rcv, rsp_id, rsp_out, e[32], e[31:0]); end
            end
            n_rcv++;
         end
         tick;
         if (c0) req0_valid = 1'b0;
         if (c1) req1_valid = 1'b0;
      end
      n_checks++; if (n_rcv !== 1000 || q.size() !== 0) begin n_fail++; $display("FAIL rand_count: got %0d rcvd/%0d pending want 1000/0", n_rcv, q.size()); end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_A = 16'd0; req0_B = 16'd0; req1_A = 16'd0; req1_B = 16'd0;
      test_reset;
      test_single_ops;
      test_back_to_back;
      test_stall;
      test_reset_abort;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
